// File: rtl/rom_burst.sv
// Read-only word store with single-read and wrapping burst-read modes.
// A word's content is its address XOR PATTERN; every result is registered and appears one cycle after it is requested.
module rom_burst #(
  parameter int                DATA_W  = 4,
  parameter int                ADDR_W  = 2,
  parameter logic [DATA_W-1:0] PATTERN = 4'hA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] len,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  output logic              busy
);

  localparam int XW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic {IDLE, BURST} state_t;

  // Handshake: valid is high for exactly one cycle per delivered word.
  // There is no backpressure. Holding en low pauses the block, and valid stays low while en is low.
  state_t              state, state_next;
  logic [DATA_W-1:0]   data_next;
  logic                valid_next, last_next;
  logic [ADDR_W-1:0]   ptr, ptr_next;
  logic [ADDR_W-1:0]   rem, rem_next;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    logic [XW-1:0] t;
    t = XW'(a) ^ XW'(PATTERN);
    return t[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= state_next;
      data  <= data_next;
      valid <= valid_next;
      last  <= last_next;
      ptr   <= ptr_next;
      rem   <= rem_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = data;
    valid_next = 1'b0;
    last_next  = 1'b0;
    ptr_next   = ptr;
    rem_next   = rem;
    if (en) begin
      unique case (state)
        IDLE: begin
          data_next  = word(addr);
          valid_next = 1'b1;
          if (start) begin
            ptr_next = addr + 1'b1;
            // len=0 wraps to DEPTH-1, which matches a burst of DEPTH words
            rem_next = len - 1'b1;
            if (len == ADDR_W'(1)) last_next  = 1'b1;
            else                   state_next = BURST;
          end
        end
        BURST: begin
          data_next  = word(ptr);
          valid_next = 1'b1;
          ptr_next   = ptr + 1'b1;
          rem_next   = rem - 1'b1;
          if (rem == ADDR_W'(1)) begin
            last_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_rom_burst.sv
// Directed bench for rom_burst at default parameters (word[0..3] = A, B, 8, 9).
module tb_rom_burst;

  localparam int W = 4;

  logic         clk, reset, en, start;
  logic [1:0]   addr, len;
  logic [W-1:0] data;
  logic         valid, last, busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rom_exp [4];

  rom_burst dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .addr  (addr),
    .len   (len),
    .data  (data),
    .valid (valid),
    .last  (last),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d, input logic v,
                           input logic l, input logic b);
    check({tag, ".data"},  32'(data),  32'(d));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".last"},  32'(last),  32'(l));
    check({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  // Pops one expected word per edge and checks it. start is cleared after the first edge.
  task automatic drain(input string tag);
    logic [W-1:0] w;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      tick();
      start = 1'b0;
      check_out(tag, w, 1'b1, exp_q.size() == 0, exp_q.size() != 0);
    end
  endtask

  initial begin
    rom_exp[0] = 4'hA; rom_exp[1] = 4'hB; rom_exp[2] = 4'h8; rom_exp[3] = 4'h9;
    reset = 1'b0; en = 1'b0; start = 1'b0; addr = '0; len = '0;
    #1 reset = 1'b1;
    #1 check_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_out("idle_en0", 4'h0, 1'b0, 1'b0, 1'b0);

    // Single reads at addresses 0 through 3
    en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      tick();
      check_out($sformatf("single%0d", a), rom_exp[a], 1'b1, 1'b0, 1'b0);
    end
    en = 1'b0;
    tick();
    check_out("hold_after_single", 4'h9, 1'b0, 1'b0, 1'b0);

    // Three-word burst starting at address 2, wrapping to 0
    en = 1'b1; start = 1'b1; addr = 2'd2; len = 2'd3;
    exp_q.push_back(4'h8); exp_q.push_back(4'h9); exp_q.push_back(4'hA);
    drain("wrap3");

    // Full burst (len=0) followed immediately by a single read
    start = 1'b1; addr = 2'd1; len = 2'd0;
    exp_q.push_back(4'hB); exp_q.push_back(4'h8);
    exp_q.push_back(4'h9); exp_q.push_back(4'hA);
    drain("full");
    addr = 2'd2;
    tick();
    check_out("b2b_single", 4'h8, 1'b1, 1'b0, 1'b0);

    // One-word burst: last is set and the block stays in IDLE
    start = 1'b1; addr = 2'd3; len = 2'd1;
    exp_q.push_back(4'h9);
    drain("len1");

    // en held low for two cycles after the first word of a full burst
    start = 1'b1; addr = 2'd0; len = 2'd0;
    tick();
    start = 1'b0;
    check_out("stall_w0", 4'hA, 1'b1, 1'b0, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out($sformatf("stall_hold%0d", i), 4'hA, 1'b0, 1'b0, 1'b1);
    end
    en = 1'b1;
    exp_q.push_back(4'hB); exp_q.push_back(4'h8); exp_q.push_back(4'h9);
    drain("stall_resume");

    // start asserted while busy has no effect on the burst in progress
    start = 1'b1; addr = 2'd1; len = 2'd3;
    tick();
    check_out("ign_w0", 4'hB, 1'b1, 1'b0, 1'b1);
    addr = 2'd0; len = 2'd1;
    tick();
    check_out("ign_w1", 4'h8, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check_out("ign_w2", 4'h9, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check_out("ign_after", 4'h9, 1'b0, 1'b0, 1'b0);

    // Reset asserted after the second word of a full burst
    en = 1'b1; start = 1'b1; addr = 2'd0; len = 2'd0;
    tick();
    start = 1'b0;
    check_out("rst_w0", 4'hA, 1'b1, 1'b0, 1'b1);
    tick();
    check_out("rst_w1", 4'hB, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 check_out("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    addr = 2'd3;
    tick();
    check_out("rst_single", 4'h9, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("rst_no_resume", 4'h9, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
